// File: rtl/hamming_encode.sv
// Two-stage SECDED encoder: stage 1 fills the Hamming parity positions of a packed
// word, stage 2 writes the overall parity bit into position 0. Valid/ready with full throughput.
module hamming_encode #(
  parameter int DATA_WIDTH = 32,
  // Smallest r with 2^r >= DATA_WIDTH + r + 1
  parameter int ADDR_WIDTH = (DATA_WIDTH <= 1)    ? 2  :
                             (DATA_WIDTH <= 4)    ? 3  :
                             (DATA_WIDTH <= 11)   ? 4  :
                             (DATA_WIDTH <= 26)   ? 5  :
                             (DATA_WIDTH <= 57)   ? 6  :
                             (DATA_WIDTH <= 120)  ? 7  :
                             (DATA_WIDTH <= 247)  ? 8  :
                             (DATA_WIDTH <= 502)  ? 9  :
                             (DATA_WIDTH <= 1013) ? 10 : 11,
  parameter int CODE_BITS  = ADDR_WIDTH + 1,
  parameter int WORD_WIDTH = DATA_WIDTH + CODE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data
);

  localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

  // Positions j (j >= 1) whose index has bit i set: the span of parity bit p_i.
  function automatic logic [WORD_WIDTH-1:0] cover_mask(input int i);
    logic [WORD_WIDTH-1:0] m;
    m = '0;
    for (int j = 1; j < WORD_WIDTH; j++) begin
      if (((j >> i) & 1) != 0) m = m | (ONE << j);
    end
    return m;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] parity_positions();
    logic [WORD_WIDTH-1:0] m;
    m = ONE;
    for (int i = 0; i < ADDR_WIDTH; i++) m = m | (ONE << (1 << i));
    return m;
  endfunction

  localparam logic [WORD_WIDTH-1:0] POS_MASK = parity_positions();

  function automatic logic [WORD_WIDTH-1:0] add_hamming_parity(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] masked;
    logic [WORD_WIDTH-1:0] r;
    masked = w & ~POS_MASK;
    r      = masked;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (^(masked & cover_mask(i))) r = r | (ONE << (1 << i));
    end
    return r;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] add_overall_parity(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] upper;
    upper = w & ~ONE;
    return upper | WORD_WIDTH'(^upper);
  endfunction

  logic                  vld_p1_q, vld_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [WORD_WIDTH-1:0] data_p1_q, data_p1_d;
  logic [WORD_WIDTH-1:0] data_p2_q, data_p2_d;
  logic                  adv1, adv2;

  always_comb begin
    adv2      = !vld_p2_q || out_ready;
    adv1      = !vld_p1_q || adv2;
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    // Stage 1 boundary: masked word with Hamming parity inserted
    if (adv1) begin
      vld_p1_d = in_valid;
      if (in_valid) data_p1_d = add_hamming_parity(in_data);
    end
    // Stage 2 boundary: overall parity into position 0
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) data_p2_d = add_overall_parity(data_p1_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p1_q <= '0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p1_q <= data_p1_d;
      data_p2_q <= data_p2_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;

endmodule

// File: tb/tb_hamming_encode.sv
// Bench for hamming_encode: directed vectors, reset, streaming, backpressure and a width sweep,
// scored against an index-XOR SECDED reference model.
module tb_hamming_encode;
  localparam int WW = 39;
  localparam int AW = 6;
  localparam int SW_DW [5] = '{1, 4, 11, 26, 57};
  localparam int SW_AW [5] = '{2, 3, 4, 5, 6};
  localparam int SW_WW [5] = '{4, 8, 16, 32, 64};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [WW-1:0] in_data, out_data;

  logic          sw_vld;
  logic [63:0]   sw_in;
  logic [4:0]    sw_ov, sw_rdy;
  logic [63:0]   sw_out [5];

  int            checks = 0;
  int            errors = 0;
  int            n_out  = 0;
  logic [WW-1:0] exp_q [$];
  logic          prev_stall;
  logic [WW-1:0] prev_data;
  logic          last_in_ready;

  always #5 clk = ~clk;

  hamming_encode #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int WG = SW_WW[g];
    logic [WG-1:0] o;
    hamming_encode #(.DATA_WIDTH(SW_DW[g])) u (
      .clk(clk), .rst(rst),
      .in_valid(sw_vld), .in_ready(sw_rdy[g]), .in_data(sw_in[WG-1:0]),
      .out_valid(sw_ov[g]), .out_ready(1'b1), .out_data(o)
    );
    assign sw_out[g] = 64'(o);
  end

  // Reference: clear parity positions, XOR the indices of set data bits to get the
  // syndrome, place it in the power-of-two slots, then make total parity even.
  function automatic logic [63:0] ref_encode(input logic [63:0] word, input int w, input int r);
    logic [63:0] c;
    int          syn;
    logic        par;
    c = '0; syn = 0; par = 1'b0;
    for (int j = 1; j < w; j++) begin
      if ((j & (j - 1)) != 0 && ((word >> j) & 64'd1) != 0) begin
        c = c | (64'd1 << j);
        syn = syn ^ j;
      end
    end
    for (int i = 0; i < r; i++) if (((syn >> i) & 1) != 0) c = c | (64'd1 << (1 << i));
    for (int j = 1; j < w; j++) par = par ^ (((c >> j) & 64'd1) != 0);
    return c | 64'(par);
  endfunction

  function automatic int syndrome_of(input logic [63:0] c, input int w);
    int s;
    s = 0;
    for (int j = 0; j < w; j++) if (((c >> j) & 64'd1) != 0) s = s ^ j;
    return s;
  endfunction

  function automatic logic parity_of(input logic [63:0] c, input int w);
    logic p;
    p = 1'b0;
    for (int j = 0; j < w; j++) p = p ^ (((c >> j) & 64'd1) != 0);
    return p;
  endfunction

  function automatic logic [63:0] width_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs driven; scores this cycle and returns at next posedge+1.
  task automatic cycle();
    logic          in_fire, out_fire;
    logic [63:0]   e64;
    logic [WW-1:0] e;
    #1;
    in_fire       = in_valid && in_ready;
    out_fire      = out_valid && out_ready;
    last_in_ready = in_ready;
    check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
    if (exp_q.size() == 2) check("out_valid_full", 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) check("out_valid_empty", 64'(out_valid), 64'd0);
    if (prev_stall) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(prev_data));
    end
    if (out_fire && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("data", 64'(out_data), 64'(e));
      check("syndrome", 64'(syndrome_of(64'(out_data), WW)), 64'd0);
      check("parity", 64'(parity_of(64'(out_data), WW)), 64'd0);
      n_out++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (in_fire) begin
      e64 = ref_encode(64'(in_data), WW, AW);
      exp_q.push_back(e64[WW-1:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic known_vector(input string tag, input logic [WW-1:0] din, input logic [WW-1:0] dexp);
    in_valid = 1'b1; in_data = din; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(dexp));
    cycle();
  endtask

  initial begin
    int base, zeros;
    logic [63:0] e;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sw_vld = 1'b0; sw_in = '0; prev_stall = 1'b0; prev_data = '0; last_in_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    known_vector("kv_zero", 39'h0, 39'h0);
    known_vector("kv_pos3", 39'h8, 39'hF);
    known_vector("kv_pos5", 39'h20, 39'h33);
    known_vector("kv_mask", 39'h8 | 39'h1 | 39'h2 | 39'h10000, 39'hF);

    // Fill both stages, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = WW'({$urandom(), $urandom()});
      cycle();
    end
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    check("held_rst_out_valid", 64'(out_valid), 64'd0);
    check("held_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 39'h20; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data", 64'(out_data), 64'h33);
    repeat (4) cycle();

    // Back-to-back stream.
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = WW'({$urandom(), $urandom()});
      if (i >= 2) check("stream_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("stream_count", 64'(n_out - base), 64'd100);

    // One-cycle out_ready drop in a continuous stream.
    zeros = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = WW'({$urandom(), $urandom()});
      out_ready = (i != 6);
      cycle();
      if (!last_in_ready) zeros++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    check("one_stall_in_ready_low", 64'(zeros), 64'd1);

    // Random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = WW'({$urandom(), $urandom()});
      out_ready = ($urandom_range(0, 9) >= 3);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Width sweep.
    for (int k = 0; k < 20; k++) begin
      sw_in = {$urandom(), $urandom()};
      sw_vld = 1'b1;
      @(posedge clk);
      #1 sw_vld = 1'b0;
      @(posedge clk);
      #1;
      for (int g = 0; g < 5; g++) begin
        e = ref_encode(sw_in & width_mask(SW_WW[g]), SW_WW[g], SW_AW[g]);
        check($sformatf("sw%0d_valid", SW_WW[g]), 64'(sw_ov[g]), 64'd1);
        check($sformatf("sw%0d_ready", SW_WW[g]), 64'(sw_rdy[g]), 64'd1);
        check($sformatf("sw%0d_data", SW_WW[g]), sw_out[g], e);
        check($sformatf("sw%0d_syndrome", SW_WW[g]), 64'(syndrome_of(sw_out[g], SW_WW[g])), 64'd0);
        check($sformatf("sw%0d_parity", SW_WW[g]), 64'(parity_of(sw_out[g], SW_WW[g])), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
